// File: rtl/ov7670_capture_pkg.sv
// Shared types and widths for the OV7670 pixel-capture stage.
package ov7670_capture_pkg;

   typedef enum logic [1:0] {
      WAIT_CFG,
      WAIT_FRAME,
      CAPTURE
   } state_e;

   localparam int unsigned RGB565_W = 16;
   localparam int unsigned BYTE_W   = 8;

endpackage

// File: rtl/ov7670_byte_packer.sv
// Packs high/low camera byte pairs into RGB565 pixels; take marks the byte that completes a pair.
module ov7670_byte_packer
   import ov7670_capture_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                href,
   input  logic [BYTE_W-1:0]   d,
   input  logic                accept,
   output logic                take,
   output logic [RGB565_W-1:0] pix_data,
   output logic                pix_valid
);

   logic                phase_q, phase_d;
   logic [BYTE_W-1:0]   hi_byte_q, hi_byte_d;
   logic [RGB565_W-1:0] pix_data_q, pix_data_d;
   logic                pix_valid_q, pix_valid_d;

   assign take = en && href && phase_q;

   always_comb begin
      phase_d     = 1'b0;
      hi_byte_d   = hi_byte_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = 1'b0;
      if (en && href) begin
         if (!phase_q) begin
            hi_byte_d = d;
            phase_d   = 1'b1;
         end else if (accept) begin
            pix_data_d  = {hi_byte_q, d};
            pix_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= 1'b0;
         hi_byte_q   <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         hi_byte_q   <= hi_byte_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture top: frame alignment FSM, vsync edge detect, frame-buffer addressing.
// Define CAPTURE_CHECK_EN to add the frame_err line/pixel geometry checker.
module ov7670_capture
   import ov7670_capture_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 320,
   parameter int unsigned V_ACTIVE = 240,
   parameter int unsigned ADDR_W   = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_done,
   input  logic                vsync,
   input  logic                href,
   input  logic [BYTE_W-1:0]   d,
   output logic [RGB565_W-1:0] pix_data,
   output logic [ADDR_W-1:0]   pix_addr,
   output logic                pix_valid,
   output logic                frame_done,
   output logic                capturing
`ifdef CAPTURE_CHECK_EN
   ,
   output logic                frame_err
`endif
);

   localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

   state_e              state_q, state_d;
   logic                vsync_q, vsync_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
   logic                frame_done_q, frame_done_d;
   logic                capturing_q, capturing_d;

   logic vs_fall, vs_rise, accept, pk_en, take;

   assign vs_fall = vsync_q && !vsync;
   assign vs_rise = !vsync_q && vsync;
   assign accept  = ({1'b0, addr_q} < PIX_TOTAL);
   // Frame end wins over a byte arriving in the same cycle.
   assign pk_en   = cfg_done && (state_q == CAPTURE) && !vs_rise;

   ov7670_byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pk_en),
      .href      (href),
      .d         (d),
      .accept    (accept),
      .take      (take),
      .pix_data  (pix_data),
      .pix_valid (pix_valid)
   );

   always_comb begin
      state_d      = state_q;
      vsync_d      = vsync;
      addr_d       = addr_q;
      pix_addr_d   = pix_addr_q;
      frame_done_d = 1'b0;
      if (!cfg_done) begin
         state_d = WAIT_CFG;
      end else begin
         unique case (state_q)
            WAIT_CFG:   state_d = WAIT_FRAME;
            WAIT_FRAME: begin
               if (vs_fall) begin
                  state_d = CAPTURE;
                  addr_d  = '0;
               end
            end
            CAPTURE: begin
               if (vs_rise) begin
                  state_d      = WAIT_FRAME;
                  frame_done_d = 1'b1;
               end else if (take && accept) begin
                  pix_addr_d = addr_q;
                  addr_d     = addr_q + ADDR_W'(1);
               end
            end
            default:    state_d = WAIT_CFG;
         endcase
      end
      capturing_d = (state_d == CAPTURE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_CFG;
         vsync_q      <= 1'b1;
         addr_q       <= '0;
         pix_addr_q   <= '0;
         frame_done_q <= 1'b0;
         capturing_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync_d;
         addr_q       <= addr_d;
         pix_addr_q   <= pix_addr_d;
         frame_done_q <= frame_done_d;
         capturing_q  <= capturing_d;
      end
   end

   assign pix_addr   = pix_addr_q;
   assign frame_done = frame_done_q;
   assign capturing  = capturing_q;

`ifdef CAPTURE_CHECK_EN
   localparam int unsigned CNT_W = 16;

   logic             href_q, href_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;
   logic             err_q, err_d;
   logic             frame_start, in_capture;

   assign frame_start = cfg_done && (state_q == WAIT_FRAME) && vs_fall;
   assign in_capture  = cfg_done && (state_q == CAPTURE);

   // Counters saturate so an oversized line or frame cannot wrap back to a legal count.
   always_comb begin
      href_d = href;
      pcnt_d = pcnt_q;
      lcnt_d = lcnt_q;
      err_d  = err_q;
      if (frame_start) begin
         pcnt_d = '0;
         lcnt_d = '0;
         err_d  = 1'b0;
      end else if (in_capture) begin
         if (vs_rise) begin
            if (lcnt_q != CNT_W'(V_ACTIVE)) err_d = 1'b1;
         end else begin
            if (take && (pcnt_q != '1)) pcnt_d = pcnt_q + CNT_W'(1);
            if (href_q && !href) begin
               if (pcnt_q != CNT_W'(H_ACTIVE)) err_d = 1'b1;
               pcnt_d = '0;
               if (lcnt_q != '1) lcnt_d = lcnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         href_q <= 1'b0;
         pcnt_q <= '0;
         lcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         href_q <= href_d;
         pcnt_q <= pcnt_d;
         lcnt_q <= lcnt_d;
         err_q  <= err_d;
      end
   end

   assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 4x3 frame geometry.
module tb_ov7670_capture;

   localparam int TB_H   = 4;
   localparam int TB_V   = 3;
   localparam int TB_AW  = 4;
   localparam int TOTAL  = TB_H * TB_V;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_done = 1'b0;
   logic              vsync = 1'b1;
   logic              href = 1'b0;
   logic [7:0]        d = '0;
   logic [15:0]       pix_data;
   logic [TB_AW-1:0]  pix_addr;
   logic              pix_valid;
   logic              frame_done;
   logic              capturing;
`ifdef CAPTURE_CHECK_EN
   logic              frame_err;
`endif

   ov7670_capture #(
      .H_ACTIVE (TB_H),
      .V_ACTIVE (TB_V),
      .ADDR_W   (TB_AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_done   (cfg_done),
      .vsync      (vsync),
      .href       (href),
      .d          (d),
      .pix_data   (pix_data),
      .pix_addr   (pix_addr),
      .pix_valid  (pix_valid),
      .frame_done (frame_done),
      .capturing  (capturing)
`ifdef CAPTURE_CHECK_EN
      ,
      .frame_err  (frame_err)
`endif
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad   = 0;
   int    cnt   = 0;
   int    n_obs = 0;
   logic  prev_valid = 1'b0;
   logic [15:0] last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pix_valid === 1'b1) begin
         n_obs++;
         chk("back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      end
      prev_valid = pix_valid;
   endtask

   task automatic drive_line(input int n, input int seed, input bit cap);
      logic [7:0] b, hi;
      hi = '0;
      for (int i = 0; i < n; i++) begin
         b = 8'((seed * 31 + i * 7 + 3) % 256);
         href = 1'b1;
         d    = b;
         tick();
         if (cap && (i % 2 == 1) && (cnt < TOTAL)) begin
            chk("pix_valid", {31'd0, pix_valid}, 32'd1);
            chk("pix_data", {16'd0, pix_data}, {16'd0, hi, b});
            chk("pix_addr", {28'd0, pix_addr}, cnt);
            last_data = {hi, b};
            cnt++;
         end else begin
            chk("pix_idle", {31'd0, pix_valid}, 32'd0);
            if (cap && cnt > 0) chk("pix_hold", {16'd0, pix_data}, {16'd0, last_data});
         end
         hi = b;
      end
      href = 1'b0;
      d    = '0;
      repeat (3) tick();
      chk("line_gap_idle", {31'd0, pix_valid}, 32'd0);
   endtask

   task automatic drive_frame(input int nlines, input int odd_line, input bit cap,
                              input int cfg_line, input int seed);
      int exp_pix;
      vsync = 1'b1;
      href  = 1'b0;
      repeat (3) tick();
      n_obs = 0;
      cnt   = 0;
      vsync = 1'b0;
      tick();
      chk("capturing_at_start", {31'd0, capturing}, {31'd0, cap});
`ifdef CAPTURE_CHECK_EN
      if (cap) chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);
`endif
      repeat (2) tick();
      for (int l = 0; l < nlines; l++) begin
         if (l == cfg_line) cfg_done = 1'b1;
         drive_line((l == odd_line) ? 2 * TB_H + 1 : 2 * TB_H, seed * 7 + l, cap);
      end
      vsync = 1'b1;
      tick();
      chk("frame_done", {31'd0, frame_done}, {31'd0, cap});
      chk("capturing_at_end", {31'd0, capturing}, 32'd0);
`ifdef CAPTURE_CHECK_EN
      if (cap) chk("frame_err", {31'd0, frame_err}, {31'd0, (nlines != TB_V)});
`endif
      tick();
      chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
      exp_pix = (nlines * TB_H < TOTAL) ? nlines * TB_H : TOTAL;
      chk("frame_pixel_count", n_obs, cap ? exp_pix : 0);
      if (cap && nlines >= TB_V) chk("final_addr_no_wrap", {28'd0, pix_addr}, TOTAL - 1);
   endtask

   typedef struct {
      logic        cfg;
      logic        vs;
      logic        hr;
      logic [7:0]  din;
      logic        exp_v;
      logic [15:0] exp_data;
      logic [3:0]  exp_addr;
      logic        exp_cap;
      logic        exp_done;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'hF8, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 16'hF800, 4'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'hF800, 4'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'hE0, 1'b1, 16'h07E0, 4'd1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h07E0, 4'd1, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 16'h07E0, 4'd1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 16'h07E0, 4'd1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h07E0, 4'd1, 1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst_pix_data", {16'd0, pix_data}, 32'd0);
      chk("rst_pix_addr", {28'd0, pix_addr}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_capturing", {31'd0, capturing}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two-pixel frame, then frame end colliding with a byte
      for (int i = 0; i < 11; i++) begin
         cfg_done = tbl[i].cfg;
         vsync    = tbl[i].vs;
         href     = tbl[i].hr;
         d        = tbl[i].din;
         tick();
         chk("vec_pix_valid", {31'd0, pix_valid}, {31'd0, tbl[i].exp_v});
         chk("vec_pix_data", {16'd0, pix_data}, {16'd0, tbl[i].exp_data});
         chk("vec_pix_addr", {28'd0, pix_addr}, {28'd0, tbl[i].exp_addr});
         chk("vec_capturing", {31'd0, capturing}, {31'd0, tbl[i].exp_cap});
         chk("vec_frame_done", {31'd0, frame_done}, {31'd0, tbl[i].exp_done});
      end

      // cfg_done low: a full frame is ignored
      cfg_done = 1'b0;
      drive_frame(TB_V, -1, 1'b0, -1, 1);

      // cfg_done rises mid-frame: that frame is skipped, the next is captured
      drive_frame(TB_V, -1, 1'b0, 1, 2);
      drive_frame(TB_V, -1, 1'b1, -1, 3);

      // Odd-length line: trailing byte discarded
      drive_frame(TB_V, 1, 1'b1, -1, 4);

      // One extra line: writes stop at the last address
      drive_frame(TB_V + 1, -1, 1'b1, -1, 5);
      drive_frame(TB_V, -1, 1'b1, -1, 6);

      // Asynchronous reset mid-line
      vsync = 1'b1;
      repeat (2) tick();
      vsync = 1'b0;
      tick();
      chk("rst6_capturing", {31'd0, capturing}, 32'd1);
      href = 1'b1;
      d    = 8'hA1;
      tick();
      d    = 8'hB2;
      tick();
      chk("rst6_pre_valid", {31'd0, pix_valid}, 32'd1);
      chk("rst6_pre_data", {16'd0, pix_data}, 32'h0000A1B2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst6_async_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst6_async_data", {16'd0, pix_data}, 32'd0);
      chk("rst6_async_addr", {28'd0, pix_addr}, 32'd0);
      chk("rst6_async_capturing", {31'd0, capturing}, 32'd0);
      tick();
      rst_n = 1'b1;
      d = 8'hC3;
      tick();
      d = 8'hD4;
      tick();
      chk("rst6_post_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst6_post_capturing", {31'd0, capturing}, 32'd0);
      href = 1'b0;
      d    = '0;
      repeat (3) tick();
      cnt = 0;
      drive_line(2 * TB_H, 40, 1'b0);
      vsync = 1'b1;
      tick();
      chk("rst6_no_frame_done", {31'd0, frame_done}, 32'd0);
      tick();
      drive_frame(TB_V, -1, 1'b1, -1, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
